// File: rtl/start_pulse_gen_if.sv
// Button front-end bundle: raw key and counter Busy in, Start/Pressed/Dropped out.
interface start_pulse_gen_if;
  logic KeyRaw;
  logic Busy;
  logic Start;
  logic Pressed;
  logic Dropped;

  modport master (
    output KeyRaw,
    output Busy,
    input  Start,
    input  Pressed,
    input  Dropped
  );

  modport slave (
    input  KeyRaw,
    input  Busy,
    output Start,
    output Pressed,
    output Dropped
  );
endinterface

// File: rtl/start_pulse_gen.sv
// Push-button front end: synchronizes and debounces a raw key into a
// single-cycle Start pulse, suppressing (and flagging) presses while Busy.
module start_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 3,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  start_pulse_gen_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
  localparam logic                 REL_LEVEL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ff1_q, ff2_q;
  logic                 start_q, start_d;
  logic                 pressed_q, pressed_d;
  logic                 dropped_q, dropped_d;
  logic                 k_c;

  // Normalised pressed level from the second synchronizer stage.
  assign k_c = ff2_q ^ REL_LEVEL;

  // Sync FFs reset to the released level so reset never fakes a press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ff1_q     <= REL_LEVEL;
      ff2_q     <= REL_LEVEL;
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      start_q   <= 1'b0;
      pressed_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      ff1_q     <= bus.KeyRaw;
      ff2_q     <= ff1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      pressed_q <= pressed_d;
      dropped_q <= dropped_d;
    end
  end

  // Press/release debounce FSM; any disagreeing sample restarts the count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    dropped_d = 1'b0;
    pressed_d = pressed_q;

    unique case (state_q)
      IDLE: begin
        if (k_c) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      PRESS_WAIT: begin
        if (!k_c) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD;
          cnt_d     = CNT_ZERO;
          pressed_d = 1'b1;
          start_d   = !bus.Busy;
          dropped_d = bus.Busy;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HELD: begin
        if (!k_c) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (k_c) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = CNT_ZERO;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign bus.Start   = start_q;
  assign bus.Pressed = pressed_q;
  assign bus.Dropped = dropped_q;

endmodule

// File: tb/tb_start_pulse_gen.sv
// Bench for start_pulse_gen: table vectors, directed corner sequences and
// randomized key/Busy traffic against a run-length reference model.
module tb_start_pulse_gen;
  localparam int unsigned DB = 4;
  localparam bit          AL = 1'b1;

  logic Clock = 1'b0;
  logic Reset;

  start_pulse_gen_if bus();

  start_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (3),
    .ACTIVE_LOW     (AL)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference: debounced level flips after DB consecutive samples that disagree with it.
  logic        m_s1, m_s2, m_level, m_start, m_drop;
  int unsigned m_run;

  function automatic void model_reset();
    m_s1 = AL; m_s2 = AL; m_level = 1'b0; m_start = 1'b0; m_drop = 1'b0; m_run = 0;
  endfunction

  function automatic void model_step();
    logic k;
    if (Reset) begin
      model_reset();
      return;
    end
    k       = m_s2 ^ AL;
    m_start = 1'b0;
    m_drop  = 1'b0;
    if (k != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = k;
        m_run   = 0;
        if (k) begin
          if (bus.Busy) m_drop = 1'b1;
          else          m_start = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = bus.KeyRaw;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    check("start_vs_model",   32'(bus.Start),   32'(m_start));
    check("pressed_vs_model", 32'(bus.Pressed), 32'(m_level));
    check("dropped_vs_model", 32'(bus.Dropped), 32'(m_drop));
  endtask

  task automatic mid_cycle_reset();
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("rst_start",   32'(bus.Start),   32'd0);
    check("rst_pressed", 32'(bus.Pressed), 32'd0);
    check("rst_dropped", 32'(bus.Dropped), 32'd0);
  endtask

  typedef struct {
    logic key;
    logic busy;
    logic st;
    logic pr;
    logic dr;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int n_start, n_drop, at, fall;
    logic key;

    // Press held 12 cycles, then released: Start at index 5, Pressed 5..16.
    for (int i = 0; i < 20; i++) begin
      vecs[i].key  = (i < 12) ? 1'b0 : 1'b1;
      vecs[i].busy = 1'b0;
      vecs[i].st   = (i == 5);
      vecs[i].pr   = (i >= 5) && (i < 17);
      vecs[i].dr   = 1'b0;
    end

    Reset      = 1'b1;
    bus.KeyRaw = 1'b1;
    bus.Busy   = 1'b0;
    model_reset();
    tick();
    tick();
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      bus.KeyRaw = vecs[i].key;
      bus.Busy   = vecs[i].busy;
      tick();
      check($sformatf("vec%0d_start", i),   32'(bus.Start),   32'(vecs[i].st));
      check($sformatf("vec%0d_pressed", i), 32'(bus.Pressed), 32'(vecs[i].pr));
      check($sformatf("vec%0d_dropped", i), 32'(bus.Dropped), 32'(vecs[i].dr));
    end
    for (int i = 0; i < 4; i++) tick();

    // Bounce low 2, high 1, then low stable: one Start 5 edges after last fall.
    n_start = 0; at = -1;
    bus.KeyRaw = 1'b0; tick(); n_start += int'(bus.Start);
    tick(); n_start += int'(bus.Start);
    bus.KeyRaw = 1'b1; tick(); n_start += int'(bus.Start);
    bus.KeyRaw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.Start) begin
        n_start++;
        if (at < 0) at = i;
      end
    end
    check("bounce_start_count", 32'(n_start), 32'd1);
    check("bounce_start_edge",  32'(at),      32'd5);

    // Release to IDLE before the Busy test.
    bus.KeyRaw = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("released_idle", 32'(bus.Pressed), 32'd0);

    // Press while Busy, Busy drops mid-hold: Dropped once, no Start, no replay.
    n_start = 0; n_drop = 0; at = -1;
    bus.Busy   = 1'b1;
    bus.KeyRaw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 7) bus.Busy = 1'b0;
      tick();
      n_start += int'(bus.Start);
      if (bus.Dropped) begin
        n_drop++;
        if (at < 0) at = i;
      end
    end
    check("busy_drop_count",  32'(n_drop),      32'd1);
    check("busy_drop_edge",   32'(at),          32'd5);
    check("busy_no_start",    32'(n_start),     32'd0);
    check("busy_pressed",     32'(bus.Pressed), 32'd1);

    // Release bounce from HELD: high 2, low 3, then high stable from edge r.
    n_start = 0; fall = -1;
    bus.KeyRaw = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); n_start += int'(bus.Start);
      check("relb_hold_hi", 32'(bus.Pressed), 32'd1);
    end
    bus.KeyRaw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); n_start += int'(bus.Start);
      check("relb_hold_lo", 32'(bus.Pressed), 32'd1);
    end
    bus.KeyRaw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_start += int'(bus.Start);
      if (!bus.Pressed && fall < 0) fall = i;
    end
    check("relb_no_start",  32'(n_start), 32'd0);
    check("relb_fall_edge", 32'(fall),    32'd5);

    // Press to HELD, then reset mid-cycle with the key released.
    bus.KeyRaw = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pre_reset_pressed", 32'(bus.Pressed), 32'd1);
    bus.KeyRaw = 1'b1;
    mid_cycle_reset();
    tick();
    tick();
    Reset = 1'b0;
    n_start = 0; n_drop = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_start += int'(bus.Start);
      n_drop  += int'(bus.Dropped);
      check("post_reset_pressed", 32'(bus.Pressed), 32'd0);
    end
    check("post_reset_no_start", 32'(n_start), 32'd0);
    check("post_reset_no_drop",  32'(n_drop),  32'd0);

    // Reset at cnt=2 in PRESS_WAIT, key held through deassertion.
    bus.KeyRaw = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pw_no_start_yet", 32'(bus.Start), 32'd0);
    mid_cycle_reset();
    tick();
    tick();
    Reset = 1'b0;
    n_start = 0; at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.Start) begin
        n_start++;
        if (at < 0) at = i;
      end
    end
    check("rst_press_count", 32'(n_start), 32'd1);
    check("rst_press_edge",  32'(at),      32'd5);

    // Randomized key/Busy/reset traffic against the model.
    key = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) key = ~key;
      bus.KeyRaw = key;
      bus.Busy   = 1'($urandom_range(0, 1));
      Reset      = ($urandom_range(0, 149) == 0);
      if (Reset) model_reset();
      tick();
    end
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
